// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared DDR state encodings and pair-order constants
package ddr_pkg;

    typedef enum logic [1:0] {
        ST_TRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } ddr_state_e;

    // Bit positions inside a {high-phase, low-phase} pair.
    localparam int HI_PHASE = 1;
    localparam int LO_PHASE = 0;

endpackage

// File: rtl/ddr_out_cell.sv
// rtl/ddr_out_cell.sv - DDR output pair registers and C-phase output mux
module ddr_out_cell
    import ddr_pkg::*;
#(
    parameter logic INIT_Q = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ce_i,
    input  logic [1:0] pair_i,
    output logic       q_o
);

    logic d1_q;
    logic d2_q;

    // Capture the next pair; clock enable low freezes the pin pattern.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            d1_q <= INIT_Q;
            d2_q <= INIT_Q;
        end else if (ce_i) begin
            d1_q <= pair_i[HI_PHASE];
            d2_q <= pair_i[LO_PHASE];
        end
    end

    // High phase of C carries d1, low phase carries d2.
    assign q_o = clk_i ? d1_q : d2_q;

endmodule

// File: rtl/ddr_out_serializer.sv
// rtl/ddr_out_serializer.sv - word-to-DDR serializer, optional training via DDR_OUT_TRAINING_EN
module ddr_out_serializer
    import ddr_pkg::*;
#(
    parameter int         WIDTH        = 8,
    parameter logic       INIT_Q       = 1'b0,
    parameter logic [1:0] IDLE_PAIR    = 2'b00,
    parameter logic [1:0] TRAIN_PAIR   = 2'b10,
    parameter int         TRAIN_CYCLES = 16
) (
    input  logic             C,
    input  logic             R_N,
    input  logic             CE,
    input  logic [WIDTH-1:0] S_DATA,
    input  logic             S_VALID,
    output logic             S_READY,
    output logic             Q,
    output logic             FRAME,
    output logic             SOF,
    output logic             TRAIN_DONE
);

    localparam int CW = $clog2(WIDTH / 2 + 1);
    localparam int TW = $clog2(TRAIN_CYCLES + 1);

    ddr_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [TW-1:0]    train_cnt_q, train_cnt_d;
    logic             frame_q, frame_d;
    logic             sof_q, sof_d;
    logic [1:0]       pair_d;
    logic             accept;
    logic             train_end;

    assign S_READY = R_N & CE &
                     ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & (count_q == CW'(1))));
    assign accept  = S_VALID & S_READY;
    assign FRAME   = frame_q;
    assign SOF     = sof_q;

    assign train_end = (state_q == ST_TRAIN) & CE & (train_cnt_q == TW'(TRAIN_CYCLES - 1));

`ifdef DDR_OUT_TRAINING_EN
    localparam ddr_state_e RESET_STATE = ST_TRAIN;
    logic train_done_q;

    // Training completion flag, sticky until the next reset.
    always_ff @(posedge C) begin
        if (!R_N) begin
            train_done_q <= 1'b0;
        end else if (train_end) begin
            train_done_q <= 1'b1;
        end
    end

    assign TRAIN_DONE = train_done_q;
`else
    localparam ddr_state_e RESET_STATE = ST_IDLE;
    assign TRAIN_DONE = 1'b1;
`endif

    // Next-state: every CE=1 branch picks the pair the cell loads.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        train_cnt_d = train_cnt_q;
        frame_d     = frame_q;
        sof_d       = sof_q;
        pair_d      = IDLE_PAIR;
        if (CE) begin
            if (state_q == ST_TRAIN) begin
                pair_d      = TRAIN_PAIR;
                train_cnt_d = train_cnt_q + TW'(1);
                frame_d     = 1'b0;
                sof_d       = 1'b0;
                if (train_end) begin
                    state_d = ST_IDLE;
                end
            end else if (accept) begin
                pair_d  = S_DATA[WIDTH-1 -: 2];
                shift_d = S_DATA << 2;
                count_d = CW'(WIDTH / 2);
                frame_d = 1'b1;
                sof_d   = 1'b1;
                state_d = ST_SHIFT;
            end else if ((state_q == ST_SHIFT) && (count_q > CW'(1))) begin
                pair_d  = shift_q[WIDTH-1 -: 2];
                shift_d = shift_q << 2;
                count_d = count_q - CW'(1);
                sof_d   = 1'b0;
            end else begin
                pair_d  = IDLE_PAIR;
                count_d = '0;
                frame_d = 1'b0;
                sof_d   = 1'b0;
                state_d = ST_IDLE;
            end
        end
    end

    // Control state register; CE=0 holds everything through the defaults.
    always_ff @(posedge C) begin
        if (!R_N) begin
            state_q     <= RESET_STATE;
            count_q     <= '0;
            shift_q     <= '0;
            train_cnt_q <= '0;
            frame_q     <= 1'b0;
            sof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            train_cnt_q <= train_cnt_d;
            frame_q     <= frame_d;
            sof_q       <= sof_d;
        end
    end

    ddr_out_cell #(
        .INIT_Q (INIT_Q)
    ) u_cell (
        .clk_i  (C),
        .rst_ni (R_N),
        .ce_i   (CE),
        .pair_i (pair_d),
        .q_o    (Q)
    );

endmodule
